// File: rtl/meteor_spawner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | meteor_pkg                                                                 |
// | Shared widths, slot record and FSM state type for the meteor spawner.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package meteor_pkg;

    localparam int METEOR_X_W = 10;
    localparam int METEOR_Y_W = 10;
    localparam int SPEED_W    = 3;
    localparam int SCREEN_W   = 640;

    typedef struct packed {
        logic                  active;
        logic [METEOR_X_W-1:0] x;
        logic [METEOR_Y_W-1:0] y;
        logic [SPEED_W-1:0]    speed;
    } meteor_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        SPAWN  = 2'd2
    } spawn_state_t;

endpackage : meteor_pkg
`default_nettype wire

// File: rtl/meteor_spawner_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | meteor_spawner_if                                                          |
// | Registered slot read port used by the sprite/collision logic.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface meteor_spawner_if #(
    parameter int NUM_METEORS = 8
);
    import meteor_pkg::*;

    localparam int IDX_W = $clog2(NUM_METEORS);

    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_active;
    logic [METEOR_X_W-1:0] rd_x;
    logic [METEOR_Y_W-1:0] rd_y;

    modport master (output rd_idx, input  rd_active, rd_x, rd_y);
    modport slave  (input  rd_idx, output rd_active, rd_x, rd_y);

endinterface : meteor_spawner_if
`default_nettype wire

// File: rtl/meteor_spawner_free_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | meteor_free_slot_find                                                      |
// | Priority encoder returning the lowest-index inactive slot.                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module meteor_free_slot_find #(
    parameter int NUM_METEORS = 8,
    parameter int IDX_W       = $clog2(NUM_METEORS)
) (
    input  logic [NUM_METEORS-1:0] active_i,
    output logic                   found_o,
    output logic [IDX_W-1:0]       index_o
);

    // Scanning downward lets the lowest free index win.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int k = NUM_METEORS - 1; k >= 0; k--) begin
            if (!active_i[k]) begin
                found_o = 1'b1;
                index_o = IDX_W'(k);
            end
        end
    end

endmodule : meteor_free_slot_find
`default_nettype wire

// File: rtl/meteor_spawner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | meteor_spawner                                                             |
// | Per-frame meteor table: advance, retire and periodically spawn meteors.    |
// | Optional feature macro: METEOR_DIFFICULTY_EN (spawn period shrinks).       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module meteor_spawner #(
    parameter int NUM_METEORS  = 8,
    parameter int SCREEN_H     = 480,
    parameter int SPAWN_PERIOD = 30,
    parameter int DROP_W       = 8
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             frame_clk,
    input  logic                             run,
    input  logic                             clear,
    input  logic [31:0]                      random_num,
    meteor_spawner_if.slave                  rd,
    output logic                             busy,
    output logic [$clog2(NUM_METEORS+1)-1:0] active_count,
    output logic [DROP_W-1:0]                drop_count
);
    import meteor_pkg::*;

    localparam int IW = $clog2(NUM_METEORS);
    localparam int CW = $clog2(NUM_METEORS + 1);
    localparam int TW = $clog2(SPAWN_PERIOD + 1);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_UPDATE = UPDATE;
    localparam logic [1:0] S_SPAWN  = SPAWN;

    if ((NUM_METEORS & (NUM_METEORS - 1)) != 0 || NUM_METEORS < 2 || NUM_METEORS > 16 ||
        SPAWN_PERIOD < 2 || SCREEN_H >= (1 << METEOR_Y_W) || SCREEN_W <= 574) begin : g_bad_cfg
        $error("meteor_spawner: unsupported parameter set");
    end

    meteor_t           slot_q [NUM_METEORS];
    meteor_t           slot_d [NUM_METEORS];
    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [17:0]       rnd_q, rnd_d;
    logic              pend_q, pend_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              fclk_q;

    logic                   w_tick;
    logic [NUM_METEORS-1:0] w_active;
    logic                   w_found;
    logic [IW-1:0]          w_free_idx;
    logic [METEOR_Y_W:0]    w_y_next;
    logic [METEOR_X_W-1:0]  w_spawn_x;
    logic [SPEED_W-1:0]     w_spawn_spd;
    logic [TW-1:0]          w_period;
    logic                   w_unused_rnd;

`ifdef METEOR_DIFFICULTY_EN
    logic [TW-1:0] period_q, period_d;
    logic [3:0]    nspawn_q, nspawn_d;
    assign w_period = period_q;
`else
    assign w_period = TW'(SPAWN_PERIOD);
`endif

    assign w_tick       = frame_clk & ~fclk_q;
    assign w_y_next     = {1'b0, slot_q[idx_q].y} + (METEOR_Y_W + 1)'(slot_q[idx_q].speed);
    assign w_spawn_x    = {1'b0, rnd_q[8:0]} + {4'd0, rnd_q[15:10]};
    assign w_spawn_spd  = {1'b0, rnd_q[17:16]} + 3'd1;
    assign w_unused_rnd = ^{random_num[31:18], rnd_q[9]};

    for (genvar k = 0; k < NUM_METEORS; k++) begin : g_active_bits
        assign w_active[k] = slot_q[k].active;
    end

    meteor_free_slot_find #(
        .NUM_METEORS (NUM_METEORS),
        .IDX_W       (IW)
    ) u_free_slot (
        .active_i (w_active),
        .found_o  (w_found),
        .index_o  (w_free_idx)
    );

    always_comb begin
        slot_d  = slot_q;
        state_d = state_q;
        idx_d   = idx_q;
        rnd_d   = rnd_q;
        pend_d  = pend_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
`ifdef METEOR_DIFFICULTY_EN
        period_d = period_q;
        nspawn_d = nspawn_q;
`endif
        if (clear) begin
            for (int k = 0; k < NUM_METEORS; k++) begin
                slot_d[k] = '0;
            end
            state_d = S_IDLE;
            idx_d   = '0;
            pend_d  = 1'b0;
            timer_d = '0;
            cnt_d   = '0;
`ifdef METEOR_DIFFICULTY_EN
            period_d = TW'(SPAWN_PERIOD);
            nspawn_d = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if ((w_tick || pend_q) && run) begin
                        rnd_d   = random_num[17:0];
                        pend_d  = 1'b0;
                        idx_d   = '0;
                        state_d = S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (w_tick && run) begin
                        pend_d = 1'b1;
                    end
                    if (slot_q[idx_q].active) begin
                        if (w_y_next >= (METEOR_Y_W + 1)'(SCREEN_H)) begin
                            slot_d[idx_q].active = 1'b0;
                            cnt_d                = cnt_q - CW'(1);
                        end else begin
                            slot_d[idx_q].y = w_y_next[METEOR_Y_W-1:0];
                        end
                    end
                    if (idx_q == IW'(NUM_METEORS - 1)) begin
                        state_d = S_SPAWN;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                S_SPAWN: begin
                    if (w_tick && run) begin
                        pend_d = 1'b1;
                    end
                    if (timer_q == w_period - TW'(1)) begin
                        timer_d = '0;
                        if (w_found) begin
                            slot_d[w_free_idx] = '{active: 1'b1, x: w_spawn_x,
                                                   y: '0, speed: w_spawn_spd};
                            cnt_d = cnt_q + CW'(1);
`ifdef METEOR_DIFFICULTY_EN
                            nspawn_d = nspawn_q + 4'd1;
                            if (nspawn_q == 4'hF && int'(period_q) > 8) begin
                                period_d = period_q - TW'(1);
                            end
`endif
                        end else if (drop_q != '1) begin
                            drop_d = drop_q + DROP_W'(1);
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            slot_q  <= '{default: '0};
            state_q <= S_IDLE;
            idx_q   <= '0;
            rnd_q   <= '0;
            pend_q  <= 1'b0;
            timer_q <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
            fclk_q  <= 1'b0;
`ifdef METEOR_DIFFICULTY_EN
            period_q <= TW'(SPAWN_PERIOD);
            nspawn_q <= '0;
`endif
        end else begin
            slot_q  <= slot_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            rnd_q   <= rnd_d;
            pend_q  <= pend_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            fclk_q  <= frame_clk;
`ifdef METEOR_DIFFICULTY_EN
            period_q <= period_d;
            nspawn_q <= nspawn_d;
`endif
        end
    end

    // Read port samples the pre-edge table, so same-cycle writes show old data.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rd.rd_active <= 1'b0;
            rd.rd_x      <= '0;
            rd.rd_y      <= '0;
        end else begin
            rd.rd_active <= slot_q[rd.rd_idx].active;
            rd.rd_x      <= slot_q[rd.rd_idx].x;
            rd.rd_y      <= slot_q[rd.rd_idx].y;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign active_count = cnt_q;
    assign drop_count   = drop_q;

endmodule : meteor_spawner
`default_nettype wire

// File: tb/tb_meteor_spawner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_meteor_spawner                                                          |
// | Frame-level reference model bench for two spawner configurations.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_meteor_spawner;
    import meteor_pkg::*;

    localparam int N = 8;
    localparam int H = 480;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, fc, run, clr;
    logic [31:0] rnd;
    logic        busy0, busy1;
    logic [3:0]  cnt0, cnt1;
    logic [7:0]  drop0, drop1;

    meteor_spawner_if #(.NUM_METEORS(N)) rif0 ();
    meteor_spawner_if #(.NUM_METEORS(N)) rif1 ();

    meteor_spawner #(.NUM_METEORS(N), .SCREEN_H(H), .SPAWN_PERIOD(30), .DROP_W(8)) u_dut0 (
        .Clk(clk), .Reset_n(rst_n), .frame_clk(fc), .run(run), .clear(clr),
        .random_num(rnd), .rd(rif0), .busy(busy0), .active_count(cnt0), .drop_count(drop0));

    meteor_spawner #(.NUM_METEORS(N), .SCREEN_H(H), .SPAWN_PERIOD(2), .DROP_W(8)) u_dut1 (
        .Clk(clk), .Reset_n(rst_n), .frame_clk(fc), .run(run), .clear(clr),
        .random_num(rnd), .rd(rif1), .busy(busy1), .active_count(cnt1), .drop_count(drop1));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: a launched frame is applied as a whole when it ends.
    int          per [2] = '{30, 2};
    int          m_act [2][N];
    int          m_x   [2][N];
    int          m_y   [2][N];
    int          m_spd [2][N];
    int          m_timer [2], m_pend [2], m_left [2], m_drop [2], m_pfc [2];
    logic [31:0] m_rnd [2];
    int          e_ok [2], e_act [2], e_x [2], e_y [2];
    bit          started = 1'b0;

    task automatic apply_frame(input int i);
        int f;
        for (int k = 0; k < N; k++) begin
            if (m_act[i][k] != 0) begin
                if (m_y[i][k] + m_spd[i][k] >= H) m_act[i][k] = 0;
                else m_y[i][k] = m_y[i][k] + m_spd[i][k];
            end
        end
        if (m_timer[i] == per[i] - 1) begin
            m_timer[i] = 0;
            f = -1;
            for (int k = 0; k < N; k++) if (m_act[i][k] == 0 && f < 0) f = k;
            if (f >= 0) begin
                m_act[i][f] = 1;
                m_x[i][f]   = int'(m_rnd[i][8:0]) + int'(m_rnd[i][15:10]);
                m_y[i][f]   = 0;
                m_spd[i][f] = int'(m_rnd[i][17:16]) + 1;
            end else if (m_drop[i] < 255) begin
                m_drop[i]++;
            end
        end else begin
            m_timer[i]++;
        end
    endtask

    task automatic model_step(input int i, input int ridx);
        bit tick;
        tick     = (fc == 1'b1) && (m_pfc[i] == 0);
        e_ok[i]  = (!rst_n || m_left[i] == 0) ? 1 : 0;
        e_act[i] = rst_n ? m_act[i][ridx] : 0;
        e_x[i]   = rst_n ? m_x[i][ridx]   : 0;
        e_y[i]   = rst_n ? m_y[i][ridx]   : 0;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                m_act[i][k] = 0; m_x[i][k] = 0; m_y[i][k] = 0; m_spd[i][k] = 0;
            end
            m_timer[i] = 0; m_pend[i] = 0; m_left[i] = 0; m_drop[i] = 0;
            m_pfc[i] = 0; m_rnd[i] = '0;
        end else begin
            m_pfc[i] = fc ? 1 : 0;
            if (clr) begin
                for (int k = 0; k < N; k++) begin
                    m_act[i][k] = 0; m_x[i][k] = 0; m_y[i][k] = 0; m_spd[i][k] = 0;
                end
                m_timer[i] = 0; m_pend[i] = 0; m_left[i] = 0;
            end else if (m_left[i] > 0) begin
                if (tick && run) m_pend[i] = 1;
                m_left[i]--;
                if (m_left[i] == 0) apply_frame(i);
            end else if ((tick || m_pend[i] != 0) && run) begin
                m_rnd[i]  = rnd;
                m_pend[i] = 0;
                m_left[i] = N + 1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, int'(rif0.rd_idx));
        model_step(1, int'(rif1.rd_idx));
        started = 1'b1;
    end

    task automatic check_inst(input int i, input logic b, input logic [3:0] c,
                              input logic [7:0] d, input logic ra,
                              input logic [9:0] rx, input logic [9:0] ry);
        int s;
        chk($sformatf("busy%0d", i), int'(b), (m_left[i] != 0) ? 1 : 0);
        if (m_left[i] == 0) begin
            s = 0;
            for (int k = 0; k < N; k++) s += m_act[i][k];
            chk($sformatf("active_count%0d", i), int'(c), s);
            chk($sformatf("drop_count%0d", i), int'(d), m_drop[i]);
        end
        if (e_ok[i] != 0) begin
            chk($sformatf("rd_active%0d", i), int'(ra), e_act[i]);
            chk($sformatf("rd_x%0d", i), int'(rx), e_x[i]);
            chk($sformatf("rd_y%0d", i), int'(ry), e_y[i]);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check_inst(0, busy0, cnt0, drop0, rif0.rd_active, rif0.rd_x, rif0.rd_y);
            check_inst(1, busy1, cnt1, drop1, rif1.rd_active, rif1.rd_x, rif1.rd_y);
        end
    end

    bit rnd_en = 1'b0;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick(input int gap);
        fc = 1'b1;
        @(negedge clk);
        fc = 1'b0;
        for (int c = 1; c < gap; c++) begin
            if (rnd_en) begin
                rif0.rd_idx = 3'($urandom_range(0, N - 1));
                rif1.rd_idx = 3'($urandom_range(0, N - 1));
                clr = ($urandom_range(0, 199) == 0);
            end
            @(negedge clk);
        end
        clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r1, d0, d1;
        logic pb0, pb1;
        rst_n = 1'b0; fc = 1'b0; run = 1'b0; clr = 1'b0; rnd = '0;
        rif0.rd_idx = '0; rif1.rd_idx = '0;
        cycles(2);
        rst_n = 1'b1; run = 1'b1;
        cycles(3);
        chk("reset_busy", int'(busy0), 0);
        chk("reset_count", int'(cnt0), 0);
        chk("reset_drop", int'(drop0), 0);
        chk("reset_rd_active", int'(rif0.rd_active), 0);

        // First spawn lands on the 30th serviced frame.
        rnd = 32'h0001_0005;
        repeat (30) tick(14);
        chk("spawn1_active", int'(rif0.rd_active), 1);
        chk("spawn1_x", int'(rif0.rd_x), 5);
        chk("spawn1_y", int'(rif0.rd_y), 0);
        chk("spawn1_count", int'(cnt0), 1);
        tick(14);
        chk("spawn1_y_after_move", int'(rif0.rd_y), 2);

        clr = 1'b1; cycles(1); clr = 1'b0;
        rnd = 32'h0003_FC10;
        repeat (30) tick(14);
        chk("spawn2_x", int'(rif0.rd_x), 79);
        chk("spawn2_y", int'(rif0.rd_y), 0);
        repeat (119) tick(14);
        chk("pre_retire_y", int'(rif0.rd_y), 476);
        chk("pre_retire_count", int'(cnt0), 4);
        tick(14);
        chk("reuse_slot0_active", int'(rif0.rd_active), 1);
        chk("reuse_slot0_y", int'(rif0.rd_y), 0);
        chk("reuse_count", int'(cnt0), 4);

        clr = 1'b1; cycles(1); clr = 1'b0;
        rnd = 32'h0000_0000;
        repeat (16) tick(14);
        chk("fill_count_p2", int'(cnt1), 8);
        repeat (600) tick(14);
        chk("drop_saturated_p2", int'(drop1), 255);

        r0 = 0; r1 = 0; pb0 = 1'b0; pb1 = 1'b0;
        for (int t = 0; t < 30; t++) begin
            if (busy0 && !pb0) r0++;
            if (busy1 && !pb1) r1++;
            pb0 = busy0; pb1 = busy1;
            fc = (t == 0 || t == 3 || t == 6);
            @(negedge clk);
        end
        fc = 1'b0;
        chk("pending_frames0", r0, 2);
        chk("pending_frames1", r1, 2);

        d0 = m_drop[0]; d1 = m_drop[1];
        fc = 1'b1; cycles(1); fc = 1'b0; cycles(3);
        fc = 1'b1; clr = 1'b1; cycles(1); fc = 1'b0; clr = 1'b0;
        chk("clear_busy0", int'(busy0), 0);
        chk("clear_busy1", int'(busy1), 0);
        chk("clear_count1", int'(cnt1), 0);
        chk("clear_drop0", int'(drop0), d0);
        chk("clear_drop1", int'(drop1), d1);
        for (int k = 0; k < N; k++) begin
            rif1.rd_idx = 3'(k);
            cycles(1);
            chk($sformatf("clear_slot%0d", k), int'(rif1.rd_active), 0);
        end

        rnd_en = 1'b1;
        repeat (200) begin
            rnd = $urandom;
            run = ($urandom_range(0, 7) != 0);
            tick($urandom_range(3, 16));
        end
        rnd_en = 1'b0;
        run = 1'b1;
        cycles(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_meteor_spawner
`default_nettype wire
